// File: rtl/int_requester.sv
// rtl/int_requester.sv - bus interrupt requester: latches a device interrupt, requests at LEVEL,
// presents VECTOR on grant until acknowledged, and re-requests if the CPU never acks.
module int_requester #(
    parameter int          LEVEL   = 4,
    parameter logic [8:0]  VECTOR  = 9'o060,
    parameter int          TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       int_req,
    input  logic       int_enable,
    input  logic [7:0] grant,
    input  logic       ack,
    output logic [7:0] asserting,
    output logic [8:0] vector,
    output logic       vector_valid,
    output logic       pending,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        VEC     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [2:0] LVL      = 3'(LEVEL);
    localparam logic [7:0] LAST     = 8'(TIMEOUT - 1);
    localparam logic [7:0] REQ_LINE = 8'(1) << LVL;

    state_t     state;
    state_t     next_state;
    logic       int_req_d;
    logic [7:0] count;
    logic [7:0] count_next;
    logic       timeout_next;
    logic       rise;
    logic       grant_lvl;
    logic       unused_grant;

    assign rise         = int_req & ~int_req_d;
    assign grant_lvl    = grant[LVL];
    assign unused_grant = ^grant;

    always_comb begin
        next_state   = state;
        count_next   = count;
        timeout_next = 1'b0;
        case (state)
            IDLE: begin
                if (pending && int_enable)
                    next_state = REQ;
            end
            REQ: begin
                // Grant takes priority over a dropped enable.
                if (grant_lvl) begin
                    next_state = VEC;
                    count_next = 8'd0;
                end else if (!int_enable) begin
                    next_state = IDLE;
                end
            end
            VEC: begin
                if (ack) begin
                    next_state = RELEASE;
                end else if (count == LAST) begin
                    next_state   = REQ;
                    timeout_next = 1'b1;
                end else begin
                    count_next = count + 8'd1;
                end
            end
            RELEASE: begin
                if (!grant_lvl)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state so they track the state register exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            int_req_d    <= 1'b0;
            count        <= 8'd0;
            pending      <= 1'b0;
            asserting    <= 8'd0;
            vector       <= 9'd0;
            vector_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= next_state;
            int_req_d    <= int_req;
            count        <= count_next;
            if (rise)
                pending <= 1'b1;
            else if (state == VEC && ack)
                pending <= 1'b0;
            asserting    <= (next_state == REQ) ? REQ_LINE : 8'd0;
            vector_valid <= (next_state == VEC);
            vector       <= (next_state == VEC) ? VECTOR : 9'd0;
            timeout      <= timeout_next;
        end
    end

endmodule

// File: tb/tb_int_requester.sv
// tb/tb_int_requester.sv - table-driven bench for int_requester (LEVEL=4, VECTOR=9'o060, TIMEOUT=4).
module tb_int_requester;

    logic       clk = 1'b0;
    logic       reset;
    logic       int_req;
    logic       int_enable;
    logic [7:0] grant;
    logic       ack;
    logic [7:0] asserting;
    logic [8:0] vector;
    logic       vector_valid;
    logic       pending;
    logic       timeout;

    int n_vec  = 0;
    int n_fail = 0;

    int_requester #(
        .LEVEL  (4),
        .VECTOR (9'o060),
        .TIMEOUT(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .int_req     (int_req),
        .int_enable  (int_enable),
        .grant       (grant),
        .ack         (ack),
        .asserting   (asserting),
        .vector      (vector),
        .vector_valid(vector_valid),
        .pending     (pending),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       req;
        logic       en;
        logic [7:0] g;
        logic       a;
        logic [7:0] e_as;
        logic       e_vv;
        logic       e_p;
        logic       e_to;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [7:0] e_as, input logic e_vv,
                         input logic e_p, input logic e_to);
        logic [8:0] e_vec;
        e_vec = e_vv ? 9'o060 : 9'd0;
        n_vec++;
        if (asserting !== e_as || vector !== e_vec || vector_valid !== e_vv ||
            pending !== e_p || timeout !== e_to) begin
            n_fail++;
            $display("FAIL %s: got as=%h vec=%o vv=%b p=%b to=%b, want as=%h vec=%o vv=%b p=%b to=%b",
                     name, asserting, vector, vector_valid, pending, timeout,
                     e_as, e_vec, e_vv, e_p, e_to);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [7:0] g, input logic a);
        int_req    = r;
        int_enable = e;
        grant      = g;
        ack        = a;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                 req  en  grant  ack  e_as   vv  p   to
        // basic transaction
        tbl.push_back(vec_t'{1'b1,1'b1,8'h00,1'b0, 8'h00,1'b0,1'b1,1'b0});
        tbl.push_back(vec_t'{1'b1,1'b1,8'h00,1'b0, 8'h10,1'b0,1'b1,1'b0});
        tbl.push_back(vec_t'{1'b1,1'b1,8'h00,1'b0, 8'h10,1'b0,1'b1,1'b0});
        tbl.push_back(vec_t'{1'b1,1'b1,8'h10,1'b0, 8'h00,1'b1,1'b1,1'b0});
        tbl.push_back(vec_t'{1'b1,1'b1,8'h10,1'b1, 8'h00,1'b0,1'b0,1'b0});
        tbl.push_back(vec_t'{1'b1,1'b1,8'h10,1'b0, 8'h00,1'b0,1'b0,1'b0});
        tbl.push_back(vec_t'{1'b1,1'b1,8'h00,1'b0, 8'h00,1'b0,1'b0,1'b0});
        tbl.push_back(vec_t'{1'b0,1'b1,8'h00,1'b0, 8'h00,1'b0,1'b0,1'b0});
        // request while disabled, enable toggling in REQ
        tbl.push_back(vec_t'{1'b1,1'b0,8'h00,1'b0, 8'h00,1'b0,1'b1,1'b0});
        tbl.push_back(vec_t'{1'b1,1'b0,8'h10,1'b0, 8'h00,1'b0,1'b1,1'b0});
        tbl.push_back(vec_t'{1'b1,1'b1,8'h00,1'b0, 8'h10,1'b0,1'b1,1'b0});
        tbl.push_back(vec_t'{1'b1,1'b0,8'h00,1'b0, 8'h00,1'b0,1'b1,1'b0});
        tbl.push_back(vec_t'{1'b1,1'b1,8'h00,1'b0, 8'h10,1'b0,1'b1,1'b0});
        // foreign grant bits ignored
        tbl.push_back(vec_t'{1'b1,1'b1,8'h20,1'b0, 8'h10,1'b0,1'b1,1'b0});
        tbl.push_back(vec_t'{1'b1,1'b1,8'h08,1'b0, 8'h10,1'b0,1'b1,1'b0});
        // vector timeout after 4 cycles, enable drop in VEC ignored
        tbl.push_back(vec_t'{1'b1,1'b1,8'h10,1'b0, 8'h00,1'b1,1'b1,1'b0});
        tbl.push_back(vec_t'{1'b1,1'b0,8'h00,1'b0, 8'h00,1'b1,1'b1,1'b0});
        tbl.push_back(vec_t'{1'b1,1'b1,8'h10,1'b0, 8'h00,1'b1,1'b1,1'b0});
        tbl.push_back(vec_t'{1'b1,1'b1,8'h00,1'b0, 8'h00,1'b1,1'b1,1'b0});
        tbl.push_back(vec_t'{1'b1,1'b1,8'h00,1'b0, 8'h10,1'b0,1'b1,1'b1});
        tbl.push_back(vec_t'{1'b0,1'b1,8'h00,1'b0, 8'h10,1'b0,1'b1,1'b0});
        // new rise on the ack edge re-requests after release
        tbl.push_back(vec_t'{1'b0,1'b1,8'h10,1'b0, 8'h00,1'b1,1'b1,1'b0});
        tbl.push_back(vec_t'{1'b1,1'b1,8'h10,1'b1, 8'h00,1'b0,1'b1,1'b0});
        tbl.push_back(vec_t'{1'b1,1'b1,8'h10,1'b0, 8'h00,1'b0,1'b1,1'b0});
        tbl.push_back(vec_t'{1'b1,1'b1,8'h00,1'b0, 8'h00,1'b0,1'b1,1'b0});
        tbl.push_back(vec_t'{1'b1,1'b1,8'h00,1'b0, 8'h10,1'b0,1'b1,1'b0});
        tbl.push_back(vec_t'{1'b1,1'b1,8'h10,1'b0, 8'h00,1'b1,1'b1,1'b0});

        drive(1'b0, 1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        #1;
        check("reset_state", 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].req, tbl[i].en, tbl[i].g, tbl[i].a);
            tick();
            check($sformatf("vec%0d", i), tbl[i].e_as, tbl[i].e_vv, tbl[i].e_p, tbl[i].e_to);
        end

        // asynchronous reset while the vector is on the bus
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_in_vec", 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        check("after_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0);

        // int_req already high when reset releases counts as a rise
        reset = 1'b1;
        drive(1'b1, 1'b1, 8'h00, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        check("rise_after_reset", 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        check("req_after_reset", 8'h10, 1'b0, 1'b1, 1'b0);

        // bounded wait for the timeout pulse, counting vector cycles
        begin
            int  vv_cycles;
            bit  seen;
            vv_cycles = 0;
            seen      = 1'b0;
            drive(1'b1, 1'b1, 8'h10, 1'b0);
            tick();
            drive(1'b1, 1'b1, 8'h00, 1'b0);
            for (int k = 0; k < 20 && !seen; k++) begin
                if (vector_valid) vv_cycles++;
                if (timeout) seen = 1'b1;
                else tick();
            end
            n_vec++;
            if (!seen || vv_cycles != 4) begin
                n_fail++;
                $display("FAIL timeout_window: seen=%b vv_cycles=%0d, want seen=1 vv_cycles=4",
                         seen, vv_cycles);
            end
            check("timeout_pulse", 8'h10, 1'b0, 1'b1, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
